// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;

  localparam int unsigned FETCH_PC_W = 32;
  localparam logic [3:0]  OPC_NOOP   = 4'hF;
  localparam logic [31:0] NOOP_WORD  = {OPC_NOOP, 28'h0};

  typedef struct packed {
    logic [FETCH_PC_W-1:0] pc;
    logic [31:0]           word;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_DROP
  } req_state_e;

endpackage

// File: rtl/fetch_buffer.sv
// Small circular FIFO of fetched {pc, word} entries; clear has priority over push/pop.
module fetch_buffer
  import fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  fetch_entry_t           i_entry,
  input  logic                   i_pop,
  input  logic                   i_clear,
  output fetch_entry_t           o_head,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr;
  logic [PTR_W-1:0] r_rd;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd];
  assign w_do_pop  = i_pop && !o_empty;
  // A pop in the same cycle frees the slot, so push into a full buffer is allowed then.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + PTR_W'(1);
      if (w_do_pop)  r_rd <= r_rd + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !i_clear) r_mem[r_wr] <= i_entry;
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC generation, req/ack imem handshake, instruction buffer and decoder output register.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       BUF_DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              rst_async,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              stall,
  input  logic              fetch_skip,
  output logic [31:0]       instruction,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              flush
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH) + 1;

  if (BUF_DEPTH < 2 || (BUF_DEPTH & (BUF_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fetch_unit: BUF_DEPTH must be a power of two and at least 2");
  end
  if (ADDR_W > FETCH_PC_W) begin : g_bad_addr_w
    $error("fetch_unit: ADDR_W exceeds the buffered PC width");
  end

  req_state_e        r_state;
  req_state_e        w_state_next;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] w_fetch_pc_next;
  logic [ADDR_W-1:0] r_pend_pc;
  logic [ADDR_W-1:0] w_pend_pc_next;
  logic [31:0]       r_instr;
  logic [ADDR_W-1:0] r_instr_pc;

  fetch_entry_t      w_push_entry;
  fetch_entry_t      w_head;
  logic              w_buf_full;
  logic              w_buf_empty;
  logic [CNT_W-1:0]  w_buf_count;
  logic [CNT_W-1:0]  w_count_next;
  logic              w_push_valid;
  logic              w_bypass;
  logic              w_buf_push;
  logic              w_pop;
  logic              w_space;

  assign imem_req    = (r_state != ST_IDLE);
  assign imem_addr   = r_fetch_pc;
  assign flush       = redirect;
  assign instruction = r_instr;
  assign instr_pc    = r_instr_pc;

  // An empty buffer forwards the acked word straight to the output register (ack N -> word N+1).
  assign w_push_valid = (r_state == ST_REQ) && imem_ack && !redirect;
  assign w_pop        = !redirect && !stall && !fetch_skip && !w_buf_empty;
  assign w_bypass     = w_push_valid && !stall && !fetch_skip && w_buf_empty;
  assign w_buf_push   = w_push_valid && !w_bypass;
  assign w_count_next = redirect ? '0
                                 : w_buf_count + CNT_W'(w_buf_push) - CNT_W'(w_pop);
  assign w_space      = (w_count_next < CNT_W'(BUF_DEPTH));
  assign w_push_entry = '{pc: FETCH_PC_W'(r_fetch_pc), word: imem_rdata};

  fetch_buffer #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk     (clk),
    .rst     (rst_async),
    .i_push  (w_buf_push),
    .i_entry (w_push_entry),
    .i_pop   (w_pop),
    .i_clear (redirect),
    .o_head  (w_head),
    .o_full  (w_buf_full),
    .o_empty (w_buf_empty),
    .o_count (w_buf_count)
  );

  // While a dropped request is outstanding the redirect target waits in r_pend_pc,
  // keeping imem_addr stable until the ack.
  always_comb begin
    w_state_next    = r_state;
    w_fetch_pc_next = r_fetch_pc;
    w_pend_pc_next  = r_pend_pc;
    unique case (r_state)
      ST_IDLE: begin
        if (redirect) w_fetch_pc_next = redirect_pc;
        w_state_next = w_space ? ST_REQ : ST_IDLE;
      end
      ST_REQ: begin
        if (imem_ack) begin
          w_fetch_pc_next = redirect ? redirect_pc : r_fetch_pc + ADDR_W'(4);
          w_state_next    = w_space ? ST_REQ : ST_IDLE;
        end else if (redirect) begin
          w_pend_pc_next = redirect_pc;
          w_state_next   = ST_DROP;
        end
      end
      ST_DROP: begin
        if (redirect) w_pend_pc_next = redirect_pc;
        if (imem_ack) begin
          w_fetch_pc_next = redirect ? redirect_pc : r_pend_pc;
          w_state_next    = w_space ? ST_REQ : ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      r_state    <= ST_IDLE;
      r_fetch_pc <= RESET_PC;
      r_pend_pc  <= RESET_PC;
    end else begin
      r_state    <= w_state_next;
      r_fetch_pc <= w_fetch_pc_next;
      r_pend_pc  <= w_pend_pc_next;
    end
  end

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      r_instr    <= NOOP_WORD;
      r_instr_pc <= RESET_PC;
    end else if (redirect) begin
      r_instr <= NOOP_WORD;
    end else if (stall) begin
      r_instr <= r_instr;
    end else if (fetch_skip) begin
      r_instr <= NOOP_WORD;
    end else if (!w_buf_empty) begin
      r_instr    <= w_head.word;
      r_instr_pc <= w_head.pc[ADDR_W-1:0];
    end else if (w_bypass) begin
      r_instr    <= imem_rdata;
      r_instr_pc <= r_fetch_pc;
    end else begin
      r_instr <= NOOP_WORD;
    end
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst_async)
    !(w_buf_push && w_buf_full));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-programmable memory model and an in-order word scoreboard.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_async = 1'b1;
  logic        imem_req, imem_ack = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0;
  logic        redirect = 1'b0, stall = 1'b0, fetch_skip = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] instruction, instr_pc;
  logic        flush;

  logic        imem_req2, imem_ack2 = 1'b0;
  logic [31:0] imem_addr2, imem_rdata2 = '0, instruction2, instr_pc2;
  logic        flush2;
  logic        zero_in = 1'b0;
  logic [31:0] zero_pc = '0;

  int unsigned tests = 0, fails = 0;
  int unsigned cyc = 0, n_deliv = 0, mem_lat = 0, mem_cnt = 0;
  logic [31:0] mem_addr_held = '0, last_word = '0;
  logic        upd_stall = 1'b1, cap2 = 1'b1;
  fetch_entry_t exp_q[$];
  logic [31:0] ack_q[$], ack2_q[$];
  int          ack_cyc [logic [31:0]];
  int          del_cyc [logic [31:0]];

  fetch_unit #(.ADDR_W(32), .BUF_DEPTH(2), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_async(rst_async), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .stall(stall), .fetch_skip(fetch_skip),
    .instruction(instruction), .instr_pc(instr_pc), .flush(flush));

  fetch_unit #(.ADDR_W(32), .BUF_DEPTH(2), .RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst_async(rst_async), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ack(imem_ack2), .imem_rdata(imem_rdata2), .redirect(zero_in),
    .redirect_pc(zero_pc), .stall(zero_in), .fetch_skip(zero_in),
    .instruction(instruction2), .instr_pc(instr_pc2), .flush(flush2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return 32'hA500_0000 ^ a;
  endfunction

  // Memory: acks after mem_lat waiting cycles; address must not move while waiting.
  always @(negedge clk) begin
    if (imem_req === 1'b1) begin
      if (mem_cnt > 0) begin
        tests++;
        assert (imem_addr === mem_addr_held) else begin
          fails++;
          $error("FAIL addr_stable: imem_addr %h required %h", imem_addr, mem_addr_held);
        end
      end else mem_addr_held = imem_addr;
      if (mem_cnt >= mem_lat) begin
        imem_ack = 1'b1; imem_rdata = word_of(imem_addr);
        ack_q.push_back(imem_addr); ack_cyc[imem_addr] = int'(cyc); mem_cnt = 0;
      end else begin
        imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF; mem_cnt++;
      end
    end else begin
      imem_ack = 1'b0; mem_cnt = 0;
    end
  end

  always @(negedge clk) begin
    imem_ack2 = imem_req2; imem_rdata2 = word_of(imem_addr2);
    if (imem_req2 === 1'b1 && cap2) ack2_q.push_back(imem_addr2);
  end

  // Scoreboard: every non-noop word produced by an unstalled edge must be the next expected entry.
  always @(negedge clk) begin
    if (rst_async === 1'b0 && !upd_stall && instruction !== NOOP_WORD) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $error("FAIL deliver: got word %h pc %h, required no word", instruction, instr_pc);
      end else begin
        fetch_entry_t e;
        e = exp_q.pop_front();
        assert (instruction === e.word && instr_pc === e.pc) else begin
          fails++;
          $error("FAIL deliver: got word %h pc %h, required word %h pc %h",
                 instruction, instr_pc, e.word, e.pc);
        end
        last_word = e.word; del_cyc[instr_pc] = int'(cyc); n_deliv++;
      end
    end
    upd_stall = stall;
  end

  always @(negedge clk) begin
    if (rst_async === 1'b0 && dut.w_buf_push === 1'b1) begin
      tests++;
      assert (dut.u_buf.o_full === 1'b0) else begin
        fails++;
        $error("FAIL push_full: full %b on push, required 0", dut.u_buf.o_full);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h required %h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] base, input int unsigned n);
    for (int unsigned i = 0; i < n; i++)
      exp_q.push_back('{pc: base + 32'(4 * i), word: word_of(base + 32'(4 * i))});
  endtask

  task automatic wait_deliv(input int unsigned n, input int unsigned budget, input string tag);
    int unsigned k = 0;
    while (n_deliv < n && k < budget) begin @(negedge clk); k++; end
    tests++;
    assert (n_deliv >= n) else begin
      fails++;
      $error("FAIL %s: delivered %0d words, required %0d", tag, n_deliv, n);
    end
  endtask

  task automatic wait_req_at(input logic [31:0] a, input string tag);
    int unsigned k = 0;
    logic found = 1'b0;
    while (!found && k < 40) begin
      @(negedge clk); k++;
      if (imem_req === 1'b1 && imem_addr === a) found = 1'b1;
    end
    chk(tag, {31'd0, found}, 32'd1);
  endtask

  task automatic restart(input logic [31:0] tgt, input int unsigned lat, input logic hold,
                         input int unsigned n);
    @(posedge clk); #2 stall = 1'b1;
    @(posedge clk); #2 redirect = 1'b1; redirect_pc = tgt; mem_lat = lat;
    @(posedge clk); #2 redirect = 1'b0; stall = hold; exp_q.delete(); n_deliv = 0;
    push_exp(tgt, n);
  endtask

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_instruction", instruction, NOOP_WORD);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    push_exp(32'h0, 32);
    @(posedge clk); #2 rst_async = 1'b0;

    // Same-cycle ack: sequential addresses, one-cycle latency, one word per cycle
    wait_deliv(6, 40, "p1_deliver");
    chk("p1_ack_addr0", ack_q[0], 32'h0);
    chk("p1_ack_addr1", ack_q[1], 32'h4);
    chk("p1_ack_addr2", ack_q[2], 32'h8);
    chk("p1_ack_addr3", ack_q[3], 32'hC);
    chk("p1_ack_to_instr", 32'(del_cyc[32'h0] - ack_cyc[32'h0]), 32'd1);
    chk("p1_rate_4", 32'(del_cyc[32'h4] - del_cyc[32'h0]), 32'd1);
    chk("p1_rate_8", 32'(del_cyc[32'h8] - del_cyc[32'h4]), 32'd1);
    chk("wrap_ack_count", 32'(ack2_q.size() >= 3), 32'd1);
    chk("wrap_addr0", ack2_q[0], 32'hFFFF_FFF8);
    chk("wrap_addr1", ack2_q[1], 32'hFFFF_FFFC);
    chk("wrap_addr2", ack2_q[2], 32'h0000_0000);
    cap2 = 1'b0;

    // Three-cycle ack latency: one word every four cycles, noops in between
    restart(32'h40, 3, 1'b0, 16);
    wait_deliv(3, 60, "p2_deliver");
    chk("p2_gap_44", 32'(del_cyc[32'h44] - del_cyc[32'h40]), 32'd4);
    chk("p2_gap_48", 32'(del_cyc[32'h48] - del_cyc[32'h44]), 32'd4);

    // fetch_skip while the buffer holds @8 and @C
    restart(32'h8, 0, 1'b1, 16);
    repeat (6) @(posedge clk);
    #2 stall = 1'b0; fetch_skip = 1'b1;
    @(posedge clk); #2 fetch_skip = 1'b0;
    @(negedge clk); chk("p3_skip_noop", instruction, NOOP_WORD);
    @(negedge clk); chk("p3_word8", instruction, word_of(32'h8));
    chk("p3_pc8", instr_pc, 32'h8);
    @(negedge clk); chk("p3_wordC", instruction, word_of(32'hC));
    chk("p3_pcC", instr_pc, 32'hC);

    // Redirect while the request to 0x10 waits for its ack
    restart(32'h10, 2, 1'b0, 0);
    wait_req_at(32'h10, "p4_req_10_seen");
    @(posedge clk); #2 redirect = 1'b1; redirect_pc = 32'h100;
    ack_q.delete(); exp_q.delete(); n_deliv = 0; push_exp(32'h100, 16);
    @(negedge clk);
    chk("p4_flush", {31'd0, flush}, 32'd1);
    chk("p4_addr_hold0", imem_addr, 32'h10);
    @(posedge clk); #2 redirect = 1'b0;
    @(negedge clk);
    chk("p4_flush_low", {31'd0, flush}, 32'd0);
    chk("p4_addr_hold1", imem_addr, 32'h10);
    @(negedge clk);
    chk("p4_next_req", {31'd0, imem_req}, 32'd1);
    chk("p4_next_addr", imem_addr, 32'h100);
    wait_deliv(3, 60, "p4_deliver");
    chk("p4_ack_dropped", ack_q[0], 32'h10);
    chk("p4_ack_target", ack_q[1], 32'h100);

    // Five-cycle stall with continuous ack: buffer fills, req drops, output held
    restart(32'h200, 0, 1'b0, 24);
    wait_deliv(2, 20, "p5_pre_deliver");
    @(posedge clk); #2 stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i > 0) chk("p5_held", instruction, last_word);
    end
    chk("p5_req_low", {31'd0, imem_req}, 32'd0);
    chk("p5_buf_full", 32'(dut.u_buf.o_count), 32'd2);
    @(posedge clk); #2 stall = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("p5_release_rate", {31'd0, instruction !== NOOP_WORD}, 32'd1);
    end

    // Reset asserted while a request waits for its ack
    restart(32'h300, 3, 1'b0, 0);
    wait_req_at(32'h300, "p6_req_300_seen");
    @(posedge clk); #2 rst_async = 1'b1; exp_q.delete();
    @(negedge clk);
    chk("p6_rst_req", {31'd0, imem_req}, 32'd0);
    chk("p6_rst_addr", imem_addr, 32'h0);
    chk("p6_rst_instr", instruction, NOOP_WORD);
    chk("p6_rst_pc", instr_pc, 32'h0);
    @(posedge clk); #2 mem_lat = 0; ack_q.delete(); n_deliv = 0; push_exp(32'h0, 16);
    rst_async = 1'b0;
    wait_deliv(4, 40, "p6_deliver");
    chk("p6_first_addr", ack_q[0], 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
